// File: rtl/usart_line_rx_if.sv
// Receive-side buffer bus of usart_line_rx: buffered word, status flags and the pop strobe.
interface usart_line_rx_if;
  logic [8:0] o_word;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_parity_err;
  logic       o_overrun;
  logic       o_busy;
  logic       i_rd;

  modport master (
    output o_word, o_valid, o_frame_err, o_parity_err, o_overrun, o_busy,
    input  i_rd
  );

  modport slave (
    input  o_word, o_valid, o_frame_err, o_parity_err, o_overrun, o_busy,
    output i_rd
  );
endinterface

// File: rtl/usart_line_rx.sv
// Line-side asynchronous USART frame receiver: 16x oversampling, majority-of-3 bit decision,
// 5..9 data bits, optional even/odd parity, single-entry holding buffer with overrun detection.
module usart_line_rx #(
  parameter int unsigned UBRR_W      = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              i_fosk,
  input  logic              i_rst,
  input  logic              i_rxd,
  input  logic [UBRR_W-1:0] i_ubrr,
  input  logic [2:0]        i_char_size,
  input  logic [1:0]        i_parity,
  usart_line_rx_if.master   rx
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [UBRR_W-1:0]      r_presc;
  logic [3:0]             r_cnt;
  logic [2:0]             r_state;
  logic [3:0]             r_bitn;
  logic [8:0]             r_shift;
  logic                   r_par;
  logic                   r_s7;
  logic                   r_s8;

  logic [8:0]             r_word;
  logic                   r_valid;
  logic                   r_ferr;
  logic                   r_perr;
  logic                   r_ovr;

  logic                   w_rxd;
  logic                   w_tick;
  logic                   w_bit;
  logic                   w_sample;
  logic                   w_end;
  logic                   w_commit;
  logic                   w_par_en;
  logic [3:0]             w_last_idx;

  assign w_rxd    = r_sync[SYNC_STAGES-1];
  assign w_tick   = (r_presc == '0);
  assign w_bit    = (r_s7 & r_s8) | (r_s7 & w_rxd) | (r_s8 & w_rxd);
  assign w_sample = w_tick && (r_cnt == 4'd9);
  assign w_end    = w_tick && (r_cnt == 4'd15);
  assign w_commit = (r_state == S_STOP) && w_sample;
  assign w_par_en = i_parity[1];

  always_comb begin
    w_last_idx = 4'd7;
    case (i_char_size)
      3'b000:  w_last_idx = 4'd4;
      3'b001:  w_last_idx = 4'd5;
      3'b010:  w_last_idx = 4'd6;
      3'b111:  w_last_idx = 4'd8;
      default: w_last_idx = 4'd7;
    endcase
  end

  always_ff @(posedge i_fosk) begin
    if (i_rst) begin
      r_sync  <= '1;
      r_prev  <= 1'b1;
      r_presc <= i_ubrr;
      r_cnt   <= '0;
      r_state <= S_IDLE;
      r_bitn  <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_s7    <= 1'b1;
      r_s8    <= 1'b1;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_rxd};
      r_prev  <= w_rxd;
      r_presc <= w_tick ? i_ubrr : r_presc - UBRR_W'(1);
      if ((r_state != S_IDLE) && w_tick) begin
        r_cnt <= r_cnt + 4'd1;
        if (r_cnt == 4'd7) r_s7 <= w_rxd;
        if (r_cnt == 4'd8) r_s8 <= w_rxd;
      end
      case (r_state)
        // Requiring r_prev=1 also keeps a low stop bit from re-triggering until the line idles high.
        S_IDLE: begin
          if (r_prev && !w_rxd) begin
            r_cnt   <= '0;
            r_bitn  <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_sample && w_bit) r_state <= S_IDLE;
          else if (w_end)        r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_sample) begin
            r_shift[r_bitn] <= w_bit;
            r_par           <= r_par ^ w_bit;
          end
          if (w_end) begin
            if (r_bitn == w_last_idx) r_state <= w_par_en ? S_PARITY : S_STOP;
            else                      r_bitn  <= r_bitn + 4'd1;
          end
        end
        S_PARITY: begin
          if (w_sample) r_par   <= r_par ^ w_bit;
          if (w_end)    r_state <= S_STOP;
        end
        S_STOP: begin
          if (w_sample) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_fosk) begin
    if (i_rst) begin
      r_word  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_commit) begin
      if (!r_valid || rx.i_rd) begin
        r_word  <= r_shift;
        r_ferr  <= ~w_bit;
        r_perr  <= w_par_en & (r_par ^ i_parity[0]);
        r_valid <= 1'b1;
        r_ovr   <= 1'b0;
      end else begin
        r_ovr <= 1'b1;
      end
    end else if (rx.i_rd && r_valid) begin
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign rx.o_word       = r_word;
  assign rx.o_valid      = r_valid;
  assign rx.o_frame_err  = r_ferr;
  assign rx.o_parity_err = r_perr;
  assign rx.o_overrun    = r_ovr;
  assign rx.o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_usart_line_rx.sv
// Directed bench for usart_line_rx: table of frame formats plus hand sequences for error/timing cases.
module tb_usart_line_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic [11:0] ubrr;
  logic [2:0]  cs;
  logic [1:0]  par;

  usart_line_rx_if bus ();

  usart_line_rx #(.UBRR_W(12), .SYNC_STAGES(2)) dut (
    .i_fosk      (clk),
    .i_rst       (rst),
    .i_rxd       (rxd),
    .i_ubrr      (ubrr),
    .i_char_size (cs),
    .i_parity    (par),
    .rx          (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   rise_cyc = -1;
  int   start_cyc = 0;
  logic mon_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_valid && !mon_prev && rise_cyc < 0) rise_cyc <= cyc;
    mon_prev <= bus.o_valid;
  end

  typedef struct {
    int         ubrr;
    logic [2:0] cs;
    logic [1:0] par;
    logic [8:0] data;
    int         nbits;
    bit         has_par;
    logic       pbit;
    logic [8:0] exp_word;
    logic       exp_perr;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk) bus.i_rd = 1'b1;
    @(negedge clk) bus.i_rd = 1'b0;
  endtask

  task automatic send_frame(input logic [8:0] data, input int nbits, input bit has_par,
                            input logic pbit, input logic stop, input int rd_at, input int tail_low);
    logic [11:0] fr;
    int nb;
    int k;
    int bl;
    bl = 16 * (int'(ubrr) + 1);
    fr = '1;
    fr[0] = 1'b0;
    for (int i = 0; i < nbits; i++) fr[1+i] = data[i];
    nb = 1 + nbits;
    if (has_par) begin
      fr[nb] = pbit;
      nb++;
    end
    fr[nb] = stop;
    nb++;
    k = 0;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < bl; j++) begin
        @(negedge clk);
        rxd = fr[b];
        bus.i_rd = (k == rd_at);
        if (k == 0) start_cyc = cyc;
        k++;
      end
    end
    for (int j = 0; j < tail_low; j++) begin
      @(negedge clk);
      rxd = 1'b0;
      bus.i_rd = 1'b0;
    end
    @(negedge clk);
    rxd = 1'b1;
    bus.i_rd = 1'b0;
  endtask

  task automatic check_buf(input string tag, input logic [8:0] w, input logic pe,
                           input logic fe, input logic ov);
    chk({tag, " valid"}, bus.o_valid, 1);
    chk({tag, " word"}, bus.o_word, w);
    chk({tag, " perr"}, bus.o_parity_err, pe);
    chk({tag, " ferr"}, bus.o_frame_err, fe);
    chk({tag, " ovr"}, bus.o_overrun, ov);
  endtask

  initial begin
    //            ubrr cs      par    data    n  hp pb  exp     pe
    vecs[0] = '{0, 3'b011, 2'b00, 9'h0A5, 8, 0, 0, 9'h0A5, 0};
    vecs[1] = '{0, 3'b111, 2'b10, 9'h1FF, 9, 1, 0, 9'h1FF, 1};
    vecs[2] = '{0, 3'b111, 2'b10, 9'h1FF, 9, 1, 1, 9'h1FF, 0};
    vecs[3] = '{1, 3'b000, 2'b11, 9'h015, 5, 1, 0, 9'h015, 0};
    vecs[4] = '{2, 3'b001, 2'b01, 9'h02A, 6, 0, 0, 9'h02A, 0};
    vecs[5] = '{1, 3'b010, 2'b11, 9'h07F, 7, 1, 1, 9'h07F, 1};
    vecs[6] = '{0, 3'b100, 2'b10, 9'h0C3, 8, 1, 0, 9'h0C3, 0};
    vecs[7] = '{0, 3'b011, 2'b00, 9'h1E5, 8, 0, 0, 9'h0E5, 0};
    vecs[8] = '{3, 3'b000, 2'b00, 9'h0FF, 5, 0, 0, 9'h01F, 0};
    vecs[9] = '{0, 3'b110, 2'b11, 9'h080, 8, 1, 0, 9'h080, 0};

    rst = 1'b1; rxd = 1'b1; ubrr = '0; cs = 3'b011; par = 2'b00; bus.i_rd = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
    chk("rst word", bus.o_word, 0);
    chk("rst valid", bus.o_valid, 0);
    chk("rst ferr", bus.o_frame_err, 0);
    chk("rst perr", bus.o_parity_err, 0);
    chk("rst ovr", bus.o_overrun, 0);
    chk("rst busy", bus.o_busy, 0);

    for (int v = 0; v < NV; v++) begin
      ubrr = 12'(vecs[v].ubrr); cs = vecs[v].cs; par = vecs[v].par;
      idle(80);
      send_frame(vecs[v].data, vecs[v].nbits, vecs[v].has_par, vecs[v].pbit, 1'b1, -1, 0);
      idle(4);
      check_buf($sformatf("v%0d", v), vecs[v].exp_word, vecs[v].exp_perr, 1'b0, 1'b0);
      if (v == 0) chk("latency 150..160", ((rise_cyc - start_cyc) >= 150) && ((rise_cyc - start_cyc) <= 160), 1);
      pop();
      chk($sformatf("v%0d pop valid", v), bus.o_valid, 0);
      chk($sformatf("v%0d pop word hold", v), bus.o_word, vecs[v].exp_word);
    end

    // Frame error with the line held low well past the stop bit, then a clean frame.
    ubrr = 12'd1; cs = 3'b011; par = 2'b00;
    idle(40);
    send_frame(9'h03C, 8, 0, 1'b0, 1'b0, -1, 100);
    idle(10);
    check_buf("ferr", 9'h03C, 1'b0, 1'b1, 1'b0);
    chk("ferr busy", bus.o_busy, 0);
    pop();
    idle(20);
    send_frame(9'h055, 8, 0, 1'b0, 1'b1, -1, 0);
    idle(4);
    check_buf("after ferr", 9'h055, 1'b0, 1'b0, 1'b0);
    pop();

    // Overrun: second frame lost, pop clears both flags.
    idle(20);
    send_frame(9'h011, 8, 0, 1'b0, 1'b1, -1, 0);
    idle(20);
    send_frame(9'h022, 8, 0, 1'b0, 1'b1, -1, 0);
    idle(4);
    check_buf("ovr", 9'h011, 1'b0, 1'b0, 1'b1);
    pop();
    chk("ovr pop valid", bus.o_valid, 0);
    chk("ovr pop ovr", bus.o_overrun, 0);

    // Start glitch shorter than half a bit.
    ubrr = 12'd3;
    idle(80);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      rxd = 1'b0;
    end
    @(negedge clk);
    rxd = 1'b1;
    chk("glitch busy", bus.o_busy, 1);
    idle(150);
    chk("glitch idle", bus.o_busy, 0);
    chk("glitch valid", bus.o_valid, 0);

    // Back-to-back frames, pop asserted on the commit cycle of the second one.
    ubrr = 12'd0;
    idle(40);
    send_frame(9'h033, 8, 0, 1'b0, 1'b1, -1, 0);
    check_buf("b2b first", 9'h033, 1'b0, 1'b0, 1'b0);
    send_frame(9'h044, 8, 0, 1'b0, 1'b1, 156, 0);
    idle(2);
    check_buf("b2b second", 9'h044, 1'b0, 1'b0, 1'b0);
    pop();
    chk("b2b pop valid", bus.o_valid, 0);
    pop();
    chk("empty pop valid", bus.o_valid, 0);
    chk("empty pop word", bus.o_word, 9'h044);

    // Reset in the middle of a frame while the buffer holds a word.
    idle(20);
    send_frame(9'h05A, 8, 0, 1'b0, 1'b1, -1, 0);
    idle(10);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      rxd = (j < 16) ? 1'b0 : 1'b1;
    end
    chk("mid busy", bus.o_busy, 1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("mid rst word", bus.o_word, 0);
    chk("mid rst valid", bus.o_valid, 0);
    chk("mid rst busy", bus.o_busy, 0);
    chk("mid rst ovr", bus.o_overrun, 0);
    idle(30);
    send_frame(9'h081, 8, 0, 1'b0, 1'b1, -1, 0);
    idle(4);
    check_buf("after rst", 9'h081, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
